// File: rtl/pulse_divider.sv
`default_nettype none
// ============================================================================
// Module   : pulse_divider
// Purpose  : Run-time programmable prescaler, one tick_out per N tick_in events,
//            free-run or one-shot. Optional macro PULSE_DIVIDER_EDGE_EN turns
//            tick_in into an async level (2-FF sync + rising-edge detect).
// Revision : 1.0 - initial release
// ============================================================================
module pulse_divider #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] div_value,
  input  logic             tick_in,
  output logic             tick_out,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_def_div = WIDTH'(DEFAULT_DIV);

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] div_q;
  logic             oneshot_q;
  logic             tick_out_q;

  logic             tick_ev;
  logic [WIDTH-1:0] div_d;
  logic [WIDTH-1:0] count_d;
  logic             is_term;

`ifdef PULSE_DIVIDER_EDGE_EN
  // [0],[1] synchronise the async level, [2] holds the previous synced value
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], tick_in};
    end
  end

  assign tick_ev = sync_q[1] & ~sync_q[2];
`else
  assign tick_ev = tick_in;
`endif

  assign div_d   = (div_value == '0) ? c_one : div_value;
  assign count_d = count_q + c_one;
  assign is_term = (count_q == (div_q - c_one));

  // Priority: stop > start > counted event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      div_q      <= c_def_div;
      oneshot_q  <= 1'b0;
      tick_out_q <= 1'b0;
    end else begin
      tick_out_q <= 1'b0;
      if (stop) begin
        state_q <= ST_IDLE;
        count_q <= '0;
      end else if (start) begin
        state_q   <= ST_RUN;
        count_q   <= '0;
        div_q     <= div_d;
        oneshot_q <= oneshot;
      end else if ((state_q == ST_RUN) && tick_ev) begin
        if (is_term) begin
          count_q    <= '0;
          tick_out_q <= 1'b1;
          state_q    <= oneshot_q ? ST_DONE : ST_RUN;
        end else begin
          count_q <= count_d;
        end
      end
    end
  end

  assign tick_out = tick_out_q;
  assign count    = count_q;
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pulse_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_divider
// Purpose  : Scoreboard bench for pulse_divider (strobe mode; edge mode when
//            PULSE_DIVIDER_EDGE_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, oneshot, tick_in;
  logic [7:0] div_value;
  logic       tick_out, busy, done;
  logic [7:0] count;

  int total = 0;
  int bad   = 0;
  int ticks_seen = 0;

  typedef struct packed {
    logic       tick;
    logic [7:0] cnt;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];

  // Reference state: 0 idle, 1 run, 2 done
  int         m_state;
  int         m_cnt;
  int         m_div;
  logic       m_os;

  pulse_divider #(.WIDTH(8), .DEFAULT_DIV(100)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .oneshot   (oneshot),
    .div_value (div_value),
    .tick_in   (tick_in),
    .tick_out  (tick_out),
    .count     (count),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cnt   = 0;
    m_div   = 100;
    m_os    = 1'b0;
  endtask

  // Predict the outputs visible after the next edge and queue them
  task automatic model_push(input logic st, input logic sp, input logic os,
                            input logic [7:0] dv, input logic ti);
    exp_t e;
    e.tick = 1'b0;
    if (sp) begin
      m_state = 0;
      m_cnt   = 0;
    end else if (st) begin
      m_state = 1;
      m_cnt   = 0;
      m_div   = (dv == 8'd0) ? 1 : int'(dv);
      m_os    = os;
    end else if (m_state == 1 && ti) begin
      if (m_cnt + 1 == m_div) begin
        e.tick  = 1'b1;
        m_cnt   = 0;
        m_state = m_os ? 2 : 1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    e.cnt  = 8'(m_cnt);
    e.busy = (m_state == 1);
    e.done = (m_state == 2);
    exp_q.push_back(e);
  endtask

  // One clock: drive, predict, then compare at #1 after the edge
  task automatic cyc(input string tag, input logic st, input logic sp,
                     input logic os, input logic [7:0] dv, input logic ti);
    exp_t e;
    start = st; stop = sp; oneshot = os; div_value = dv; tick_in = ti;
    model_push(st, sp, os, dv, ti);
    @(posedge clk);
    #1;
    if (tick_out) ticks_seen++;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_tick"}, int'(tick_out), int'(e.tick));
      chk({tag, "_count"}, int'(count), int'(e.cnt));
      chk({tag, "_busy"}, int'(busy), int'(e.busy));
      chk({tag, "_done"}, int'(done), int'(e.done));
    end
  endtask

  // Non-start cycle with junk on div_value/oneshot, which must be ignored
  task automatic tk(input string tag, input logic ti);
    cyc(tag, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), ti);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; oneshot = 1'b0;
    div_value = 8'd0; tick_in = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_tick", int'(tick_out), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

`ifndef PULSE_DIVIDER_EDGE_EN
    // Reset in the middle of a period at count 37
    cyc("t1_start", 1'b1, 1'b0, 1'b0, 8'd50, 1'b0);
    for (int i = 0; i < 37; i++) tk("t1_run", 1'b1);
    chk("t1_count37", int'(count), 37);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_async_tick", int'(tick_out), 0);
    chk("t1_async_count", int'(count), 0);
    chk("t1_async_busy", int'(busy), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ticks_seen = 0;
    for (int i = 0; i < 5; i++) tk("t1_idle", 1'b1);
    chk("t1_no_ticks", ticks_seen, 0);

    // Free-run divide by 4
    ticks_seen = 0;
    cyc("t2_start", 1'b1, 1'b0, 1'b0, 8'd4, 1'b0);
    for (int i = 0; i < 12; i++) tk("t2_run", 1'b1);
    chk("t2_ticks", ticks_seen, 3);
    tk("t2_gap", 1'b0);
    tk("t2_gap2", 1'b0);

    // One-shot divide by 3
    ticks_seen = 0;
    cyc("t3_start", 1'b1, 1'b0, 1'b1, 8'd3, 1'b0);
    for (int i = 0; i < 7; i++) tk("t3_run", 1'b1);
    chk("t3_ticks", ticks_seen, 1);
    chk("t3_done", int'(done), 1);
    chk("t3_busy", int'(busy), 0);
    chk("t3_count", int'(count), 0);

    // Zero divide ratio behaves as 1
    ticks_seen = 0;
    cyc("t4_pre", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    cyc("t4_start", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 3; i++) tk("t4_run", 1'b1);
    chk("t4_ticks", ticks_seen, 3);
    tk("t4_gap", 1'b0);

    // stop wins over the terminal tick
    ticks_seen = 0;
    cyc("t5_start", 1'b1, 1'b0, 1'b0, 8'd5, 1'b0);
    for (int i = 0; i < 4; i++) tk("t5_run", 1'b1);
    cyc("t5_stop", 1'b0, 1'b1, 1'b0, 8'd9, 1'b1);
    chk("t5_stop_ticks", ticks_seen, 0);
    chk("t5_stop_busy", int'(busy), 0);
    tk("t5_idle", 1'b1);

    // start wins over the terminal tick
    cyc("t5b_start", 1'b1, 1'b0, 1'b0, 8'd5, 1'b0);
    for (int i = 0; i < 4; i++) tk("t5b_run", 1'b1);
    cyc("t5b_restart", 1'b1, 1'b0, 1'b0, 8'd5, 1'b1);
    chk("t5b_ticks", ticks_seen, 0);
    chk("t5b_busy", int'(busy), 1);
    chk("t5b_count", int'(count), 0);
    for (int i = 0; i < 5; i++) tk("t5b_reload", 1'b1);
    chk("t5b_reload_ticks", ticks_seen, 1);
`else
    // Edge mode: two 10-cycle high levels, divide by 2
    begin
      int tick_iter;
      tick_iter  = -1;
      ticks_seen = 0;
      start = 1'b1; div_value = 8'd2; oneshot = 1'b0; tick_in = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("t6_busy", int'(busy), 1);
      for (int c = 0; c < 40; c++) begin
        tick_in = ((c < 10) || (c >= 15 && c < 25)) ? 1'b1 : 1'b0;
        @(posedge clk);
        #1;
        if (tick_out) begin
          ticks_seen++;
          tick_iter = c;
        end
        if (c == 12) chk("t6_count_after_first", int'(count), 1);
      end
      chk("t6_ticks", ticks_seen, 1);
      chk("t6_tick_cycle", tick_iter, 17);
      chk("t6_count_end", int'(count), 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
